// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver, LSB first, 460800 baud from a 50 MHz clock. Counterpart of
// the serial audio link transmitter (same frame format and bit period).
//
// The asynchronous line is brought into the clock domain through a two-flop
// synchronizer. A falling edge on an idle line starts a frame. The start bit is
// confirmed at its midpoint, and every later bit is sampled one bit period
// after the previous sample, so all samples stay close to mid-bit. The receiver
// returns to IDLE at the stop-bit midpoint, which lets back-to-back frames
// follow with no idle gap.
//
// Ports:
//   CLOCK_50      in   system clock (50 MHz), single clock domain
//   Reset         in   asynchronous assert, active-high reset
//   Serial_In     in   asynchronous serial line, idle high
//   Output_Data   out  [7:0] last correctly framed byte
//   Data_Valid    out  one-cycle pulse when Output_Data has been updated
//   Framing_Error out  one-cycle pulse when the stop bit is sampled low
//   Busy          out  high whenever the receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 108,
    parameter int HALF_BIT     = 54
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Serial_In,
    output logic [7:0] Output_Data,
    output logic       Data_Valid,
    output logic       Framing_Error,
    output logic       Busy
);

    // Terminal counts of the 7-bit cycle counter.
    localparam logic [6:0] LAST_TICK = 7'(CLKS_PER_BIT - 1);
    localparam logic [6:0] HALF_TICK = 7'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t      state_q,     state_d;
    logic [6:0]  clk_count_q, clk_count_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  data_q,      data_d;
    logic        valid_q,     valid_d;
    logic        ferr_q,      ferr_d;

    // Synchronizer flops reset to the idle (high) line level so that reset
    // release never looks like a start edge.
    logic        sync1_q;
    logic        sync2_q;
    logic        rx_sync;

    assign rx_sync = sync2_q;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= Serial_In;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            clk_count_q <= 7'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    // Next-state logic. The cycle counter free-runs inside a state and is
    // cleared whenever the state changes or a bit period completes.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q + 7'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_count_d = 7'd0;
                if (!rx_sync) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // Re-check the line at the start-bit midpoint; a line that is
                // high again was only a glitch.
                if (clk_count_q == HALF_TICK) begin
                    clk_count_d = 7'd0;
                    if (!rx_sync) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (clk_count_q == LAST_TICK) begin
                    clk_count_d = 7'd0;
                    // LSB arrives first, so shifting right leaves bit 0 in
                    // place after the eighth sample.
                    shift_d     = {rx_sync, shift_q[7:1]};
                    bit_idx_d   = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (clk_count_q == LAST_TICK) begin
                    clk_count_d = 7'd0;
                    if (rx_sync) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // A line held low after a bad stop bit must go high before
                // another start edge can be recognised.
                clk_count_d = 7'd0;
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                clk_count_d = 7'd0;
            end
        endcase
    end

    assign Output_Data   = data_q;
    assign Data_Valid    = valid_q;
    assign Framing_Error = ferr_q;
    assign Busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. A serializer task drives whole frames onto
// the line; a monitor records every Data_Valid / Framing_Error pulse and every
// Busy transition with its cycle number. The expected result of each frame is
// taken from the frame itself: a high stop bit yields exactly one Data_Valid
// carrying the transmitted byte, a low stop bit yields exactly one
// Framing_Error and leaves the last good byte on Output_Data.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] out_data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx dut (
        .CLOCK_50      (clk),
        .Reset         (rst),
        .Serial_In     (rx),
        .Output_Data   (out_data),
        .Data_Valid    (data_valid),
        .Framing_Error (frame_err),
        .Busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] dv_data_q[$];
    int         dv_cyc_q[$];
    int         fe_cyc_q[$];
    int         gap_q[$];      // Busy-low run lengths, pushed at each Busy rise
    int         hi_q[$];       // Busy-high run lengths, pushed at each Busy fall

    initial begin
        logic prev_dv;
        logic prev_fe;
        logic prev_busy;
        int   busy_edge_cyc;
        prev_dv       = 1'b0;
        prev_fe       = 1'b0;
        prev_busy     = 1'b0;
        busy_edge_cyc = 0;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1 || frame_err === 1'b1) begin
                check("dv_fe_exclusive", {31'b0, data_valid & frame_err}, 32'd0);
                check("pulse_one_cycle", {31'b0, prev_dv | prev_fe}, 32'd0);
            end
            if (data_valid === 1'b1) begin
                dv_data_q.push_back(out_data);
                dv_cyc_q.push_back(cyc);
                $display("rx byte 0x%02h at cycle %0d", out_data, cyc);
            end
            if (frame_err === 1'b1) begin
                fe_cyc_q.push_back(cyc);
                $display("framing error at cycle %0d", cyc);
            end
            if (busy === 1'b1 && !prev_busy) begin
                gap_q.push_back(cyc - busy_edge_cyc);
                busy_edge_cyc = cyc;
            end
            if (busy !== 1'b1 && prev_busy) begin
                hi_q.push_back(cyc - busy_edge_cyc);
                busy_edge_cyc = cyc;
            end
            prev_dv   = (data_valid === 1'b1);
            prev_fe   = (frame_err === 1'b1);
            prev_busy = (busy === 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] model_last = 8'h00;   // last correctly framed byte

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first and the stop bit, each bitc cycles.
    // Called and returns on a falling clock edge.
    task automatic send(input logic [7:0] b, input int bitc, input logic stop_bit,
                        output int edge_cyc);
        rx = 1'b0;
        edge_cyc = cyc;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitc) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bitc) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input int bitc, input logic stop_ok,
                             input int hold_low, input string tag);
        int n_dv;
        int n_fe;
        int e;
        n_dv = dv_data_q.size();
        n_fe = fe_cyc_q.size();
        send(b, bitc, stop_ok, e);
        if (!stop_ok) begin
            repeat (hold_low) @(negedge clk);
            check({tag, "_break_busy"}, {31'b0, busy}, 32'd1);
            rx = 1'b1;
            repeat (20) @(negedge clk);
        end
        $display("frame %s byte=0x%02h bitc=%0d stop=%0b", tag, b, bitc, stop_ok);
        if (stop_ok) begin
            check({tag, "_dv_count"}, dv_data_q.size() - n_dv, 32'd1);
            check({tag, "_fe_count"}, fe_cyc_q.size() - n_fe, 32'd0);
            if (dv_data_q.size() > n_dv) begin
                check({tag, "_data"}, {24'b0, dv_data_q[n_dv]}, {24'b0, b});
                if (bitc == 108)
                    check({tag, "_latency"}, dv_cyc_q[n_dv] - e, 32'd1029);
            end
            model_last = b;
        end else begin
            check({tag, "_fe_count"}, fe_cyc_q.size() - n_fe, 32'd1);
            check({tag, "_dv_count"}, dv_data_q.size() - n_dv, 32'd0);
        end
        check({tag, "_out_data"}, {24'b0, out_data}, {24'b0, model_last});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n_dv;
        int n_fe;
        int e;

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_valid",    {31'b0, data_valid}, 32'd0);
        check("rst_ferr",     {31'b0, frame_err}, 32'd0);
        check("rst_busy",     {31'b0, busy}, 32'd0);
        rst = 1'b0;
        idle(10);

        // Single nominal frame
        run_frame(8'hA5, 108, 1'b1, 0, "single_a5");
        idle(30);

        // Back-to-back frames, no idle gap
        n_dv = dv_data_q.size();
        gap_q.delete();
        run_frame(8'h00, 108, 1'b1, 0, "b2b_00");
        run_frame(8'hFF, 108, 1'b1, 0, "b2b_ff");
        run_frame(8'h3C, 108, 1'b1, 0, "b2b_3c");
        idle(10);
        if (dv_data_q.size() >= n_dv + 3) begin
            check("b2b_spacing1", dv_cyc_q[n_dv + 1] - dv_cyc_q[n_dv], 32'd1080);
            check("b2b_spacing2", dv_cyc_q[n_dv + 2] - dv_cyc_q[n_dv + 1], 32'd1080);
        end else begin
            check("b2b_pulses", dv_data_q.size() - n_dv, 32'd3);
        end
        check("b2b_busy_rises", gap_q.size(), 32'd3);
        if (gap_q.size() >= 3) begin
            check("b2b_idle_gap1", gap_q[1], 32'd54);
            check("b2b_idle_gap2", gap_q[2], 32'd54);
        end

        // Glitch rejection
        n_dv = dv_data_q.size();
        n_fe = fe_cyc_q.size();
        hi_q.delete();
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(150);
        check("glitch_dv", dv_data_q.size() - n_dv, 32'd0);
        check("glitch_fe", fe_cyc_q.size() - n_fe, 32'd0);
        check("glitch_busy_pulses", hi_q.size(), 32'd1);
        if (hi_q.size() >= 1)
            check("glitch_busy_len", hi_q[0], 32'd54);
        check("glitch_out_data", {24'b0, out_data}, {24'b0, model_last});

        // Low stop bit, line held low, then a good frame
        run_frame(8'h5A, 108, 1'b0, 500, "ferr_5a");
        idle(10);
        run_frame(8'h11, 108, 1'b1, 0, "after_ferr_11");
        idle(10);

        // Reset in the middle of DATA (bit 4). Bits 4..7 of 0xF0 and the stop
        // bit are high, so nothing looks like a start edge after release.
        n_dv = dv_data_q.size();
        n_fe = fe_cyc_q.size();
        fork
            send(8'hF0, 108, 1'b1, e);
            begin
                repeat (108 * 5 + 20) @(negedge clk);
                rst = 1'b1;
                #1;
                check("midrst_out_data", {24'b0, out_data}, 32'd0);
                check("midrst_busy",     {31'b0, busy}, 32'd0);
                check("midrst_valid",    {31'b0, data_valid}, 32'd0);
                check("midrst_ferr",     {31'b0, frame_err}, 32'd0);
                model_last = 8'h00;
                @(negedge clk);
                repeat (30) @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(200);
        check("midrst_no_dv", dv_data_q.size() - n_dv, 32'd0);
        check("midrst_no_fe", fe_cyc_q.size() - n_fe, 32'd0);
        run_frame(8'h81, 108, 1'b1, 0, "after_rst_81");
        idle(20);

        // Bit period skew
        run_frame(8'hC3, 106, 1'b1, 0, "skew106_c3");
        idle(20);
        run_frame(8'hC3, 110, 1'b1, 0, "skew110_c3");
        idle(20);

        // Randomized frames: random byte, bit period, stop bit and gaps
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            int         bitc;
            logic       ok;
            b    = 8'($urandom_range(0, 255));
            bitc = int'($urandom_range(106, 110));
            ok   = ($urandom_range(0, 4) != 0);
            run_frame(b, bitc, ok, int'($urandom_range(0, 200)), $sformatf("rnd%0d", i));
            idle(int'($urandom_range(0, 40)));
        end
        idle(50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
